// File: rtl/lcd_seq_ctrl_pkg.sv
// lcd_pkg: shared state encodings and LCD1602 command constants for the
// lcd_seq_ctrl sequencer. Optional feature macro: LCD_DIRTY_SKIP_EN adds the
// IDLE main state used to skip unchanged frames.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_L1_ADDR,
        ST_L1_CHR,
        ST_L2_ADDR,
        ST_L2_CHR,
        ST_FRAME_END
`ifdef LCD_DIRTY_SKIP_EN
        , ST_IDLE
`endif
    } lcd_state_e;

    typedef enum logic [2:0] {
        H_IDLE,
        H_SETUP,
        H_ASSERT,
        H_WAIT,
        H_RELEASE
    } hs_state_e;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_LINE1_ADDR  = 8'h80;
    localparam logic [7:0] LCD_LINE2_ADDR  = 8'hC0;
    localparam int         LCD_COLS        = 16;

    // Initialisation command issued at position idx of the INIT phase.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = LCD_CMD_FUNCSET;
            2'd1:    init_cmd = LCD_CMD_DISPON;
            2'd2:    init_cmd = LCD_CMD_CLEAR;
            default: init_cmd = LCD_CMD_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/lcd_seq_ctrl_xfer_hs.sv
// lcd_xfer_hs: moves one byte through the LCD driver's start/done handshake.
// Start is held for a fixed 3-cycle blanking window so that the done flag
// left over from the previous byte is never mistaken for completion.
module lcd_xfer_hs
    import lcd_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       i_req,
    input  logic [7:0] i_data,
    input  logic       i_rs,
    output logic       o_accepted,
    output logic [7:0] o_drv_data,
    output logic       o_drv_rs,
    output logic       o_drv_start,
    input  logic       iDRV_DONE
);

    hs_state_e  r_state;
    hs_state_e  w_state_nxt;
    logic [1:0] r_blank_cnt;
    logic [7:0] r_data;
    logic       r_rs;
    logic       r_start;

    // Handshake state register.
    always_ff @(posedge iCLK) begin
        if (iRST) r_state <= H_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state decode and the one-cycle accept report.
    always_comb begin
        w_state_nxt = r_state;
        o_accepted  = 1'b0;
        case (r_state)
            H_IDLE:    if (i_req) w_state_nxt = H_SETUP;
            H_SETUP:   w_state_nxt = H_ASSERT;
            H_ASSERT:  if (r_blank_cnt == 2'd2) w_state_nxt = H_WAIT;
            H_WAIT:    if (iDRV_DONE) w_state_nxt = H_RELEASE;
            H_RELEASE: begin
                o_accepted  = 1'b1;
                w_state_nxt = H_IDLE;
            end
            default:   w_state_nxt = H_IDLE;
        endcase
    end

    // Blanking counter: counts the cycles spent in H_ASSERT.
    always_ff @(posedge iCLK) begin
        if (iRST)                     r_blank_cnt <= 2'd0;
        else if (r_state == H_ASSERT) r_blank_cnt <= r_blank_cnt + 2'd1;
        else                          r_blank_cnt <= 2'd0;
    end

    // Byte/RS capture in H_IDLE; held until the next request is taken.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_data <= 8'h00;
            r_rs   <= 1'b0;
        end else if (r_state == H_IDLE && i_req) begin
            r_data <= i_data;
            r_rs   <= i_rs;
        end
    end

    // Registered start: high exactly while in H_ASSERT or H_WAIT.
    always_ff @(posedge iCLK) begin
        if (iRST) r_start <= 1'b0;
        else      r_start <= (w_state_nxt == H_ASSERT) || (w_state_nxt == H_WAIT);
    end

    assign o_drv_data  = r_data;
    assign o_drv_rs    = r_rs;
    assign o_drv_start = r_start;

endmodule

// File: rtl/lcd_seq_ctrl.sv
// lcd_seq_ctrl: power-up wait, LCD1602 init, then repeated copy of a 32-byte
// host buffer to both display lines through lcd_xfer_hs.
// Optional feature macro: LCD_DIRTY_SKIP_EN (skip frames when nothing was
// written since the last frame started; otherwise refresh continuously).
module lcd_seq_ctrl
    import lcd_pkg::*;
#(
    parameter int PWRUP_CYCLES = 15000,
    parameter int CLK_HZ       = 1000000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iWR_EN,
    input  logic [4:0] iWR_ADDR,
    input  logic [7:0] iWR_DATA,
    output logic       oREADY,
    output logic       oFRAME_DONE,
    output logic [7:0] oDRV_DATA,
    output logic       oDRV_RS,
    output logic       oDRV_START,
    input  logic       iDRV_DONE
);

    localparam int PWR_W = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWRUP_CYCLES - 1);

    // CLK_HZ only documents the intended clock; catch nonsense settings early.
    if (CLK_HZ <= 0 || PWRUP_CYCLES < 1) begin : g_bad_param
        $error("lcd_seq_ctrl: CLK_HZ and PWRUP_CYCLES must be positive");
    end

    lcd_state_e       r_state;
    lcd_state_e       w_state_nxt;
    logic [PWR_W-1:0] r_pwr_cnt;
    logic [3:0]       r_idx;
    logic             r_ready;
    logic             r_frame_done;
    logic [7:0]       r_buf [32];
    logic [4:0]       w_rd_addr;
    logic [7:0]       w_rd_data;
    logic             w_req;
    logic [7:0]       w_byte;
    logic             w_rs;
    logic             w_accepted;
`ifdef LCD_DIRTY_SKIP_EN
    logic             r_dirty;
`endif

    // Character index maps to line 2 only while line 2 characters are sent;
    // a same-cycle host write to that address is forwarded to the reader.
    assign w_rd_addr = {(r_state == ST_L2_CHR), r_idx};
    assign w_rd_data = (iWR_EN && (iWR_ADDR == w_rd_addr)) ? iWR_DATA : r_buf[w_rd_addr];

    // Main sequencer state register.
    always_ff @(posedge iCLK) begin
        if (iRST) r_state <= ST_PWRUP;
        else      r_state <= w_state_nxt;
    end

    // Main next-state decode and the byte requested from the handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_byte      = 8'h00;
        w_rs        = 1'b0;
        case (r_state)
            ST_PWRUP: if (r_pwr_cnt == PWR_LAST) w_state_nxt = ST_INIT;
            ST_INIT: begin
                w_req  = 1'b1;
                w_byte = init_cmd(r_idx[1:0]);
                if (w_accepted && r_idx == 4'd3) w_state_nxt = ST_L1_ADDR;
            end
            ST_L1_ADDR: begin
                w_req  = 1'b1;
                w_byte = LCD_LINE1_ADDR;
                if (w_accepted) w_state_nxt = ST_L1_CHR;
            end
            ST_L1_CHR: begin
                w_req  = 1'b1;
                w_byte = w_rd_data;
                w_rs   = 1'b1;
                if (w_accepted && r_idx == 4'(LCD_COLS - 1)) w_state_nxt = ST_L2_ADDR;
            end
            ST_L2_ADDR: begin
                w_req  = 1'b1;
                w_byte = LCD_LINE2_ADDR;
                if (w_accepted) w_state_nxt = ST_L2_CHR;
            end
            ST_L2_CHR: begin
                w_req  = 1'b1;
                w_byte = w_rd_data;
                w_rs   = 1'b1;
                if (w_accepted && r_idx == 4'(LCD_COLS - 1)) w_state_nxt = ST_FRAME_END;
            end
            ST_FRAME_END: begin
`ifdef LCD_DIRTY_SKIP_EN
                w_state_nxt = r_dirty ? ST_L1_ADDR : ST_IDLE;
`else
                w_state_nxt = ST_L1_ADDR;
`endif
            end
`ifdef LCD_DIRTY_SKIP_EN
            ST_IDLE: if (r_dirty) w_state_nxt = ST_L1_ADDR;
`endif
            default: w_state_nxt = ST_PWRUP;
        endcase
    end

    // Power-on delay counter, only advances while waiting in PWRUP.
    always_ff @(posedge iCLK) begin
        if (iRST)                     r_pwr_cnt <= '0;
        else if (r_state == ST_PWRUP) r_pwr_cnt <= r_pwr_cnt + 1'b1;
    end

    // Byte index within the current phase; restarts on every phase change.
    always_ff @(posedge iCLK) begin
        if (iRST)                          r_idx <= 4'd0;
        else if (w_state_nxt != r_state)   r_idx <= 4'd0;
        else if (w_accepted)               r_idx <= r_idx + 4'd1;
    end

    // Ready latches when INIT completes; frame-done marks the FRAME_END cycle.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_ready      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (r_state == ST_INIT && w_state_nxt != ST_INIT) r_ready <= 1'b1;
            r_frame_done <= (w_state_nxt == ST_FRAME_END);
        end
    end

    // Host character buffer; cleared to spaces so a blank panel shows on reset.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
        end else if (iWR_EN) begin
            r_buf[iWR_ADDR] <= iWR_DATA;
        end
    end

`ifdef LCD_DIRTY_SKIP_EN
    // Dirty flag: any write sets it (winning over the clear on frame start).
    always_ff @(posedge iCLK) begin
        if (iRST)                                                     r_dirty <= 1'b0;
        else if (iWR_EN)                                              r_dirty <= 1'b1;
        else if (w_state_nxt == ST_L1_ADDR && r_state != ST_L1_ADDR)  r_dirty <= 1'b0;
    end
`endif

    lcd_xfer_hs u_xfer_hs (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .i_req       (w_req),
        .i_data      (w_byte),
        .i_rs        (w_rs),
        .o_accepted  (w_accepted),
        .o_drv_data  (oDRV_DATA),
        .o_drv_rs    (oDRV_RS),
        .o_drv_start (oDRV_START),
        .iDRV_DONE   (iDRV_DONE)
    );

    assign oREADY      = r_ready;
    assign oFRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Bench for lcd_seq_ctrl: random driver latency, random buffer writes,
// scoreboard of expected {RS,byte} transactions checked at each start rise.
module tb_lcd_seq_ctrl;

    localparam int PW = 20;

    logic       clk;
    logic       iRST;
    logic       iWR_EN;
    logic [4:0] iWR_ADDR;
    logic [7:0] iWR_DATA;
    logic       oREADY;
    logic       oFRAME_DONE;
    logic [7:0] oDRV_DATA;
    logic       oDRV_RS;
    logic       oDRV_START;
    logic       iDRV_DONE;

    lcd_seq_ctrl #(.PWRUP_CYCLES(PW), .CLK_HZ(1000000)) dut (
        .iCLK        (clk),
        .iRST        (iRST),
        .iWR_EN      (iWR_EN),
        .iWR_ADDR    (iWR_ADDR),
        .iWR_DATA    (iWR_DATA),
        .oREADY      (oREADY),
        .oFRAME_DONE (oFRAME_DONE),
        .oDRV_DATA   (oDRV_DATA),
        .oDRV_RS     (oDRV_RS),
        .oDRV_START  (oDRV_START),
        .iDRV_DONE   (iDRV_DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [7:0] model[32];
    int         popped = 0;
    int         fall_cnt = 0;
    int         fd_seen = 0;
    bit         skip_fall = 0;
    bit         done_fresh = 0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    // A frame as the display should see it: address, line 1, address, line 2.
    task automatic push_frame();
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, model[i]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, model[i]});
    endtask

    // Driver model: clears done 2 cycles after a start rise, sets it later.
    int   clr_cnt = 0;
    int   set_cnt = 0;
    logic drv_prev = 1'b0;
    initial begin
        logic rst_s, st_s;
        iDRV_DONE = 1'b0;
        forever begin
            @(posedge clk);
            rst_s = iRST;
            st_s  = oDRV_START;
            #1;
            if (rst_s) begin
                iDRV_DONE  = 1'b0;
                clr_cnt    = 0;
                set_cnt    = 0;
                drv_prev   = 1'b0;
                done_fresh = 0;
            end else begin
                if (st_s && !drv_prev) begin
                    clr_cnt    = 1;
                    set_cnt    = $urandom_range(2, 11);
                    done_fresh = 0;
                end else begin
                    if (clr_cnt > 0) begin
                        clr_cnt--;
                        if (clr_cnt == 0) iDRV_DONE = 1'b0;
                    end
                    if (set_cnt > 0) begin
                        set_cnt--;
                        if (set_cnt == 0) begin
                            iDRV_DONE  = 1'b1;
                            done_fresh = 1;
                        end
                    end
                end
                drv_prev = st_s;
            end
        end
    end

    // Monitor: pops the scoreboard on each start rise and checks protocol.
    initial begin
        logic       st_prev = 1'b0;
        logic       fd_prev = 1'b0;
        logic [8:0] cur = '0;
        logic [8:0] e;
        int         high_len = 0;
        forever begin
            @(negedge clk);
            if (oDRV_START === 1'b1 && st_prev === 1'b0) begin
                chk(oREADY == (fall_cnt >= 4), "ready_level", oREADY, (fall_cnt >= 4));
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_byte", {oDRV_RS, oDRV_DATA}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({oDRV_RS, oDRV_DATA} == e, "byte", {oDRV_RS, oDRV_DATA}, e);
                end
                cur      = {oDRV_RS, oDRV_DATA};
                high_len = 1;
                popped++;
            end else if (oDRV_START === 1'b1) begin
                high_len++;
                chk({oDRV_RS, oDRV_DATA} == cur, "data_stable", {oDRV_RS, oDRV_DATA}, cur);
            end
            if (oDRV_START === 1'b0 && st_prev === 1'b1) begin
                if (skip_fall) begin
                    skip_fall = 0;
                end else begin
                    chk(high_len >= 3, "start_hold", high_len, 3);
                    chk(done_fresh, "drop_before_done", 0, 1);
                    fall_cnt++;
                end
            end
            if (oFRAME_DONE === 1'b1) begin
                chk(fd_prev !== 1'b1, "frame_done_width", 2, 1);
                chk(popped == 4 + 34 * (fd_seen + 1), "frame_len", popped, 4 + 34 * (fd_seen + 1));
                fd_seen++;
            end
            st_prev = oDRV_START;
            fd_prev = oFRAME_DONE;
        end
    end

    task automatic first_start(input bit hello);
        logic [7:0] hw[5];
        int n;
        hw = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        n = 0;
        while (n < PW + 40) begin
            @(posedge clk); #1;
            n++;
            if (oDRV_START) break;
            if (hello && n <= 5) begin
                iWR_EN = 1'b1; iWR_ADDR = 5'(n - 1); iWR_DATA = hw[n-1];
            end else begin
                iWR_EN = 1'b0;
            end
        end
        iWR_EN = 1'b0;
        chk(n == PW + 2, "first_start_cycle", n, PW + 2);
    endtask

    task automatic wait_fd();
        bit got = 0;
        for (int n = 0; n < 6000 && !got; n++) begin
            @(posedge clk); #1;
            if (oFRAME_DONE) got = 1;
        end
        chk(got, "frame_done_timeout", 0, 1);
    endtask

    task automatic rand_writes();
        int nw;
        logic [4:0] a[4];
        logic [7:0] d[4];
        nw = $urandom_range(1, 4);
        for (int k = 0; k < nw; k++) begin
            a[k] = 5'($urandom_range(0, 31));
            if (a[k] == 5'd17) a[k] = 5'd18;
            d[k] = 8'($urandom_range(33, 126));
            model[a[k]] = d[k];
        end
        push_frame();
        for (int k = 0; k < nw; k++) begin
            iWR_EN = 1'b1; iWR_ADDR = a[k]; iWR_DATA = d[k];
            @(posedge clk); #1;
        end
        iWR_EN = 1'b0;
    endtask

    task automatic wait_popped(input int target);
        int n = 0;
        while (popped < target && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(popped >= target, "wait_byte_timeout", popped, target);
    endtask

    initial begin
        int base;
        iRST = 1'b1; iWR_EN = 1'b0; iWR_ADDR = '0; iWR_DATA = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(oDRV_START == 1'b0, "rst_start", oDRV_START, 0);
        chk(oDRV_DATA == 8'h00, "rst_data", oDRV_DATA, 0);
        chk(oDRV_RS == 1'b0, "rst_rs", oDRV_RS, 0);
        chk(oREADY == 1'b0, "rst_ready", oREADY, 0);
        chk(oFRAME_DONE == 1'b0, "rst_frame_done", oFRAME_DONE, 0);
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        model[0] = 8'h48; model[1] = 8'h45; model[2] = 8'h4C; model[3] = 8'h4C; model[4] = 8'h4F;
        push_init();
        push_frame();
        iRST = 1'b0;
        first_start(1'b1);
        wait_fd();

`ifdef LCD_DIRTY_SKIP_EN
        base = popped;
        repeat (300) @(posedge clk);
        #1;
        chk(popped == base, "idle_no_bytes", popped - base, 0);
        chk(oDRV_START == 1'b0, "idle_start_low", oDRV_START, 0);
        model[9] = 8'h5A;
        push_frame();
        iWR_EN = 1'b1; iWR_ADDR = 5'd9; iWR_DATA = 8'h5A;
        @(posedge clk); #1;
        iWR_EN = 1'b0;
        wait_fd();
        base = popped;
        repeat (300) @(posedge clk);
        #1;
        chk(popped == base, "idle_after_one_frame", popped - base, 0);
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
`else
        rand_writes();
        wait_fd();

        // Write buf[17] in the very cycle the controller samples it.
        model[17] = 8'h41;
        push_frame();
        base = popped;
        wait_popped(base + 19);
        for (int n = 0; n < 100 && oDRV_START; n++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        iWR_EN = 1'b1; iWR_ADDR = 5'd17; iWR_DATA = 8'h41;
        @(posedge clk); #1;
        iWR_EN = 1'b0;
        wait_fd();

        rand_writes();
        base = popped;
        wait_popped(base + 22);
        iRST = 1'b1;
        @(posedge clk); #1;
        chk(oDRV_START == 1'b0, "midframe_rst_start", oDRV_START, 0);
        skip_fall = 1;
        iRST = 1'b0;
        exp_q.delete();
        popped = 0; fall_cnt = 0; fd_seen = 0;
        chk(oREADY == 1'b0, "midframe_rst_ready", oREADY, 0);
        chk(oDRV_DATA == 8'h00, "midframe_rst_data", oDRV_DATA, 0);
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        push_init();
        push_frame();
        first_start(1'b0);
        wait_fd();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_seq_ctrl.md
# lcd_seq_ctrl

Sequencer that sits above the LCD1602 byte driver and owns it exclusively. After power-up it waits out the panel's power-on delay, then issues the fixed initialisation command sequence. It then repeatedly copies a 32-byte host-writable character buffer to the two 16-character display lines, one command or data byte per driver transaction, using the driver's start/done handshake.

## Interface
Parameters:
- PWRUP_CYCLES, 15000 — iCLK cycles to wait after reset before the first command (15 ms at 1 MHz).
- CLK_HZ, 1000000 — informational only; no logic depends on it.

Ports:
- iCLK  in  1  system clock, 1 MHz, shared with the driver.
- iRST  in  1  reset. One clock; reset is synchronous and active-high.
- iWR_EN  in  1  host buffer write strobe.
- iWR_ADDR  in  5  buffer address: 0–15 is line 1, 16–31 is line 2.
- iWR_DATA  in  8  ASCII/CGROM code.
- oREADY  out  1  high once init is complete; stays high until reset.
- oFRAME_DONE  out  1  one-cycle pulse after the last character of a frame is accepted.
- oDRV_DATA  out  8  byte presented to the driver.
- oDRV_RS  out  1  0 = command, 1 = data.
- oDRV_START  out  1  driver start request; the driver triggers on the rising edge.
- iDRV_DONE  in  1  driver completion flag. Level, set by the driver on completion, cleared by the driver about 2 cycles after a new rising start edge.

## Operation
- Main FSM: PWRUP → INIT → LINE1_ADDR → LINE1_CHR → LINE2_ADDR → LINE2_CHR → FRAME_END → (IDLE | LINE1_ADDR).
- PWRUP: a counter runs from 0 to PWRUP_CYCLES-1, then the FSM moves to INIT.
- INIT issues 0x38, 0x0C, 0x01, 0x06 in order, all with RS=0. oREADY rises in the cycle INIT exits.
- LINE1_ADDR issues 0x80 (RS=0). LINE1_CHR issues buf[0..15] (RS=1).
- LINE2_ADDR issues 0xC0 (RS=0). LINE2_CHR issues buf[16..31] (RS=1).
- FRAME_END pulses oFRAME_DONE.
- Each byte goes through the handshake sub-FSM, which has these states:
  - H_IDLE: load oDRV_DATA and oDRV_RS; go to H_SETUP.
  - H_SETUP: one cycle with data stable and start low.
  - H_ASSERT: start goes high; hold for exactly 3 cycles, ignoring iDRV_DONE (the stale done from the previous byte).
  - H_WAIT: start stays high until iDRV_DONE=1.
  - H_RELEASE: start goes low for one cycle; report "byte accepted" to the main FSM.
- oDRV_DATA and oDRV_RS hold constant from H_SETUP through H_RELEASE.
- Buffer: 32×8 registers. A host write is accepted in any state, including during PWRUP and INIT.
- Read/write collision: a write and a controller read of the same address in the same cycle returns the new data. The read is combinational from the register array and is sampled in H_IDLE.
- There is no timeout on iDRV_DONE. The driver guarantees completion by polling the busy flag.
- Reset at any point: start drops low, all FSMs go to PWRUP/H_IDLE, and the buffer clears to 0x20 (space). An in-flight driver transaction is abandoned; the team resets the driver from the same source.

## Timing
- Reset values:
  - oDRV_START=0, oDRV_DATA=0x00, oDRV_RS=0.
  - oREADY=0, oFRAME_DONE=0.
  - Buffer is all 0x20.
- First oDRV_START rise occurs at PWRUP_CYCLES+2 cycles after reset release.
- Per-byte overhead beyond the driver's own latency is 5 cycles (IDLE, SETUP, RELEASE, plus the 2 extra cycles of the 3-cycle blanking).
- Minimum start-low time between bytes is 3 cycles (RELEASE, IDLE, SETUP).
- A frame is 34 transactions.
- oFRAME_DONE fires the cycle after H_RELEASE of buf[31].

## Configuration
- LCD_DIRTY_SKIP_EN defined:
  - A dirty flag is set by any iWR_EN.
  - FRAME_END goes to IDLE if dirty=0, else to LINE1_ADDR.
  - Dirty is cleared on entry to LINE1_ADDR. A write in that same cycle keeps it set (set wins).
  - The first frame after init is always sent.
- LCD_DIRTY_SKIP_EN undefined: FRAME_END always goes to LINE1_ADDR (continuous refresh). The IDLE state and the dirty flag are absent.

## Structure
- Package lcd_pkg holds:
  - the main and handshake state enums;
  - LCD_CMD_FUNCSET=0x38, LCD_CMD_DISPON=0x0C, LCD_CMD_CLEAR=0x01, LCD_CMD_ENTRY=0x06;
  - LCD_LINE1_ADDR=0x80, LCD_LINE2_ADDR=0xC0;
  - LCD_COLS=16.
- One sub-module, lcd_xfer_hs, contains the handshake sub-FSM. Its interface is req/data/rs in, accepted out, and the driver start/done pins.

## Test plan
- Reset release with PWRUP_CYCLES=20 and a driver model (done 10 cycles after start) → first start rise at cycle 22; command bytes 0x38, 0x0C, 0x01, 0x06 with RS=0; oREADY high after the 4th accept.
- Write "HELLO" to addresses 0–4 during PWRUP → first frame shows 0x80, H, E, L, L, O, then eleven 0x20, then 0xC0 and sixteen 0x20; oFRAME_DONE pulses once.
- Driver model holds done high from the previous byte → start is held for ≥3 cycles and never dropped before done is re-asserted; no byte is skipped.
- Write addr 17=0x41 in the same cycle the controller samples buf[17] → 0x41 is sent.
- With LCD_DIRTY_SKIP_EN, no writes after frame 1 → FSM sits in IDLE and start stays low; a single write → exactly one further frame is sent.
- Assert iRST mid-LINE2_CHR → start low the next cycle, buffer returns to 0x20, full PWRUP/INIT sequence repeats.
